lab5_tap_feeder: RTL and testbench

Upstream feeder for the lab 5 multiply-sum datapath. It accepts a stream of 10-bit signed samples over a valid/ready handshake and buffers bursts in a small FIFO. It maintains a 3-tap delay line and presents the taps as `x1` (newest), `x2` and `x3` (oldest), with a one-cycle `taps_valid` strobe on each update. Tap updates are paced so that they occur no more often than once every `PACE` cycles, which matches the datapath's throughput.

---
 rtl/lab5_pkg.sv | 10 +
 rtl/lab5_tap_feeder_if.sv | 15 +
 rtl/lab5_sample_fifo.sv | 53 +++++
 rtl/lab5_tap_feeder.sv | 108 ++++++++++
 tb/tb_lab5_tap_feeder.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab5_pkg.sv
// Shared types for the lab 5 tap feeder: sample format and feeder FSM states.
package lab5_pkg;

  localparam int SAMPLE_W = 10;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {FILL, RUN} feed_state_t;

endpackage

// File: rtl/lab5_tap_feeder_if.sv
// Valid/ready sample stream feeding the tap feeder.
interface lab5_tap_feeder_if
  import lab5_pkg::*;
#(
  parameter int W = SAMPLE_W
);

  logic signed [W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/lab5_sample_fifo.sv
// Small pointer-based FIFO; the extra pointer bit separates full from empty.
module lab5_sample_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;
  logic         do_push;
  logic         do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata = mem[rptr[AW-1:0]];

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else if (clear) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/lab5_tap_feeder.sv
// Buffers incoming samples and shifts them into a paced 3-tap delay line.
module lab5_tap_feeder
  import lab5_pkg::*;
#(
  parameter int W     = SAMPLE_W,
  parameter int DEPTH = 4,
  parameter int PACE  = 2
) (
  input  logic                clk,
  input  logic                reset,
  lab5_tap_feeder_if.slave    src,
  input  logic                flush,
  output logic signed [W-1:0] x1,
  output logic signed [W-1:0] x2,
  output logic signed [W-1:0] x3,
  output logic                taps_valid
);

  localparam int PW = (PACE > 1) ? $clog2(PACE) : 1;
  localparam logic [PW-1:0] PACE_LOAD = PW'(PACE - 1);
  localparam logic [PW-1:0] PACE_ONE  = PW'(1);

  feed_state_t         state, state_nxt;
  logic [1:0]          fill_cnt, fill_nxt;
  logic                tv_nxt;
  logic [PW-1:0]       pace_cnt;
  logic signed [W-1:0] head;
  logic                full;
  logic                empty;
  logic                accept;
  logic                shift;

  assign src.in_ready = !full && !flush && !reset;
  assign accept       = src.in_valid && src.in_ready;
  assign shift        = !empty && (pace_cnt == '0) && !flush;

  lab5_sample_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (shift),
    .clear (flush),
    .wdata (src.in_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill_cnt;
    tv_nxt    = 1'b0;
    if (flush) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end else if (shift) begin
      unique case (state)
        FILL: begin
          fill_nxt = fill_cnt + 2'd1;
          if (fill_cnt == 2'd2) begin
            state_nxt = RUN;
            tv_nxt    = 1'b1;
          end
        end
        RUN: tv_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      fill_cnt   <= '0;
      taps_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      fill_cnt   <= fill_nxt;
      taps_valid <= tv_nxt;
    end
  end

  // Pace counter reloads on each shift and rests at zero until the next one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pace_cnt <= '0;
      x1       <= '0;
      x2       <= '0;
      x3       <= '0;
    end else if (flush) begin
      pace_cnt <= '0;
      x1       <= '0;
      x2       <= '0;
      x3       <= '0;
    end else if (shift) begin
      x3       <= x2;
      x2       <= x1;
      x1       <= head;
      pace_cnt <= PACE_LOAD;
    end else if (pace_cnt != '0) begin
      pace_cnt <= pace_cnt - PACE_ONE;
    end
  end

endmodule

// File: tb/tb_lab5_tap_feeder.sv
// Directed bench for lab5_tap_feeder: a queue-level model checked every cycle plus literal taps checks.
module tb_lab5_tap_feeder;
  import lab5_pkg::*;

  localparam int DEPTH  = 4;
  localparam int PACE_A = 2;
  localparam int PACE_B = 1;
  localparam int EVMAX  = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic    v  [2];
  sample_t d  [2];
  logic    fl [2];

  lab5_tap_feeder_if #(.W(SAMPLE_W)) if_a ();
  lab5_tap_feeder_if #(.W(SAMPLE_W)) if_b ();

  assign if_a.in_valid = v[0];
  assign if_a.in_data  = d[0];
  assign if_b.in_valid = v[1];
  assign if_b.in_data  = d[1];

  sample_t a_x1, a_x2, a_x3, b_x1, b_x2, b_x3;
  logic    a_tv, b_tv;

  lab5_tap_feeder #(.W(SAMPLE_W), .DEPTH(DEPTH), .PACE(PACE_A)) u_dut_a (
    .clk        (clk),
    .reset      (reset),
    .src        (if_a),
    .flush      (fl[0]),
    .x1         (a_x1),
    .x2         (a_x2),
    .x3         (a_x3),
    .taps_valid (a_tv)
  );

  lab5_tap_feeder #(.W(SAMPLE_W), .DEPTH(DEPTH), .PACE(PACE_B)) u_dut_b (
    .clk        (clk),
    .reset      (reset),
    .src        (if_b),
    .flush      (fl[1]),
    .x1         (b_x1),
    .x2         (b_x2),
    .x3         (b_x3),
    .taps_valid (b_tv)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a sample queue, a 3-entry delay line, a count of real samples and a cooldown.
  bit signed [SAMPLE_W-1:0] mf [2][16];
  bit signed [SAMPLE_W-1:0] mt [2][3];
  int mh [2], mc [2], mreal [2], mcool [2];
  bit mtv [2];

  function automatic int pace_of(input int k);
    return (k == 0) ? PACE_A : PACE_B;
  endfunction

  task automatic model_clear_one(input int k);
    mh[k] = 0; mc[k] = 0; mreal[k] = 0; mcool[k] = 0; mtv[k] = 1'b0;
    for (int i = 0; i < 3; i++) mt[k][i] = '0;
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (fl[k]) begin
        model_clear_one(k);
      end else begin
        bit sh, acc;
        sh  = (mc[k] > 0) && (mcool[k] == 0);
        acc = v[k] && (mc[k] < DEPTH);
        if (sh) begin
          mt[k][2] = mt[k][1];
          mt[k][1] = mt[k][0];
          mt[k][0] = mf[k][mh[k]];
          mh[k]    = (mh[k] + 1) % 16;
          mc[k]    = mc[k] - 1;
          if (mreal[k] < 3) mreal[k] = mreal[k] + 1;
          mtv[k]   = (mreal[k] == 3);
          mcool[k] = pace_of(k) - 1;
        end else begin
          mtv[k] = 1'b0;
          if (mcool[k] > 0) mcool[k] = mcool[k] - 1;
        end
        if (acc) begin
          mf[k][(mh[k] + mc[k]) % 16] = d[k];
          mc[k] = mc[k] + 1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      model_clear_one(0);
      model_clear_one(1);
    end else begin
      model_step();
    end
  end

  // Log of taps seen on each taps_valid pulse, and of back-pressure observations.
  sample_t ev1 [2][EVMAX];
  sample_t ev2 [2][EVMAX];
  sample_t ev3 [2][EVMAX];
  int evn [2];
  int nr  [2];

  task automatic cmp(input int k, input sample_t x1, input sample_t x2, input sample_t x3,
                     input logic tv, input logic rdy);
    logic exp_rdy;
    exp_rdy = !reset && !fl[k] && (mc[k] < DEPTH);
    check($sformatf("x1[%0d]", k), int'(x1), int'(mt[k][0]));
    check($sformatf("x2[%0d]", k), int'(x2), int'(mt[k][1]));
    check($sformatf("x3[%0d]", k), int'(x3), int'(mt[k][2]));
    check($sformatf("taps_valid[%0d]", k), int'(tv), int'(mtv[k]));
    check($sformatf("in_ready[%0d]", k), int'(rdy), int'(exp_rdy));
    if (!reset && tv === 1'b1 && evn[k] < EVMAX) begin
      ev1[k][evn[k]] = x1;
      ev2[k][evn[k]] = x2;
      ev3[k][evn[k]] = x3;
      evn[k]++;
    end
    if (!reset && v[k] && rdy === 1'b0 && !fl[k]) nr[k]++;
  endtask

  always @(negedge clk) begin
    cmp(0, a_x1, a_x2, a_x3, a_tv, if_a.in_ready);
    cmp(1, b_x1, b_x2, b_x3, b_tv, if_b.in_ready);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds one sample until accepted; returns #1 after the accepting edge.
  task automatic push(input int k, input int val);
    int   tries;
    logic rdy;
    tries = 0;
    d[k]  = val[SAMPLE_W-1:0];
    v[k]  = 1'b1;
    forever begin
      @(negedge clk);
      rdy = (k == 0) ? if_a.in_ready : if_b.in_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      tries++;
      if (tries > 100) begin
        check("push_timeout", 0, 1);
        break;
      end
    end
    v[k] = 1'b0;
  endtask

  task automatic pulse_flush(input int k);
    fl[k] = 1'b1;
    idle(1);
    fl[k] = 1'b0;
  endtask

  // Expects n pulses since base, with taps (first+i, first+i-1, first+i-2).
  task automatic check_events(input int k, input int base, input int n, input int first, input string tag);
    check({tag, "_count"}, evn[k] - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < EVMAX) begin
        check($sformatf("%s_x1_%0d", tag, i), int'(ev1[k][base+i]), first + i);
        check($sformatf("%s_x2_%0d", tag, i), int'(ev2[k][base+i]), first + i - 1);
        check($sformatf("%s_x3_%0d", tag, i), int'(ev3[k][base+i]), first + i - 2);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded its time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, nrbase;
    logic [SAMPLE_W-1:0] bits;

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      v[k] = 1'b0; d[k] = '0; fl[k] = 1'b0;
    end
    @(negedge clk);
    check("rst_x1", int'(a_x1), 0);
    check("rst_tv", int'(a_tv), 0);
    check("rst_ready", int'(if_a.in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill: only the third shift raises taps_valid.
    base = evn[0];
    push(0, 1); push(0, 2); push(0, 3);
    idle(8);
    check_events(0, base, 1, 3, "fill");

    // Burst with back-pressure.
    pulse_flush(0);
    base   = evn[0];
    nrbase = nr[0];
    for (int i = 10; i <= 17; i++) push(0, i);
    idle(16);
    check_events(0, base, 6, 12, "burst");
    check("burst_backpressure", int'(nr[0] > nrbase), 1);

    // Flush in RUN discards the simultaneous sample.
    push(0, 5);
    idle(4);
    check("preflush_x1", int'(a_x1), 5);
    fl[0] = 1'b1; v[0] = 1'b1; d[0] = 10'sd99;
    idle(1);
    fl[0] = 1'b0; v[0] = 1'b0;
    check("flush_x1", int'(a_x1), 0);
    check("flush_x2", int'(a_x2), 0);
    check("flush_x3", int'(a_x3), 0);
    base = evn[0];
    push(0, 7); push(0, 8); push(0, 9);
    idle(8);
    check_events(0, base, 1, 9, "flush");

    // Extremes are carried bit-exact.
    pulse_flush(0);
    base = evn[0];
    push(0, -512); push(0, 511); push(0, -1);
    idle(8);
    check("ext_count", evn[0] - base, 1);
    bits = a_x1; check("ext_x1_bits", int'(bits), 'h3FF);
    bits = a_x2; check("ext_x2_bits", int'(bits), 'h1FF);
    bits = a_x3; check("ext_x3_bits", int'(bits), 'h200);
    check("ext_x3", int'(a_x3), -512);

    // Reset mid-cycle with two entries buffered.
    pulse_flush(0);
    push(0, 21); push(0, 22); push(0, 23); push(0, 24);
    #2 reset = 1'b1;
    #1;
    check("midrst_x1", int'(a_x1), 0);
    check("midrst_x2", int'(a_x2), 0);
    check("midrst_x3", int'(a_x3), 0);
    check("midrst_tv", int'(a_tv), 0);
    check("midrst_ready", int'(if_a.in_ready), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    base = evn[0];
    push(0, 31); push(0, 32); push(0, 33);
    idle(8);
    check_events(0, base, 1, 33, "postrst");

    // PACE = 1: push and pop in every cycle, order preserved.
    base = evn[1];
    for (int i = 40; i <= 49; i++) push(1, i);
    idle(6);
    check_events(1, base, 8, 42, "pace1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
